mix_cols_seq: RTL and testbench
===============================

# mix_cols_seq

Sequenced MixColumns engine for the AES-128 round datapath. It accepts one 128-bit state per transaction and runs the four columns through a single shared `mul_cols_enc` column unit, one column per cycle. It returns the mixed state over a valid/ready handshake. A per-transaction bypass flag serves the final AES round, which skips MixColumns.

## Interface
Parameters: none. The state width is fixed at 128 bits (4 columns × 32 bits).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  `in_data` and `in_bypass` are presented
- `in_ready`  out  1  block can accept a state; high only in IDLE
- `in_data`  in  128  AES state; column c = bits [127-32c -: 32], so column 0 is [127:96]
- `in_bypass`  in  1  pass the state through unmixed (final round)
- `out_valid`  out  1  `out_data` holds a completed result
- `out_ready`  in  1  downstream accepts `out_data`
- `out_data`  out  128  mixed (or bypassed) state, held stable while `out_valid` is high
- `busy`  out  1  high in BUSY or DONE

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: load `in_data` into the 128-bit state register.
  - If `in_bypass`=1, go to DONE.
  - Otherwise clear the 2-bit column counter `col` to 0 and go to BUSY.
- BUSY:
  - Column `col` of the state register drives the `mul_cols_enc` input.
  - Its output is written back into the same column slot, in place. Other columns are untouched.
  - `col` increments by 1. When `col`==3, the write completes and the FSM goes to DONE. `col` wraps to 0 and is unused in DONE.
  - `in_valid` is ignored; `in_ready`=0.
- DONE:
  - `out_valid`=1 and `out_data` = state register.
  - On `out_ready`=1, go to IDLE; the register contents are retained.
  - `out_ready`=0 holds DONE indefinitely, with `out_data` stable.
- No input is accepted in BUSY or DONE. No pipelining or overlap.
- Column arithmetic is entirely in `mul_cols_enc` (GF(2^8), polynomial 0x11B). The controller only selects and writes back 32-bit slices.
- `out_data` is a direct view of the state register. It is only meaningful while `out_valid`=1.

## Timing
- Reset values: `in_ready`=1 once `rst` is released (0 while asserted is acceptable), `out_valid`=0, `busy`=0, `out_data`=0, `col`=0, FSM=IDLE.
- Handshakes:
  - Input accept on cycle T means `in_valid`&`in_ready` are sampled high at the edge ending T.
  - Output transfer is the cycle with `out_valid`&`out_ready` both high.
- Mix latency: BUSY occupies cycles T+1..T+4 (columns 0,1,2,3). `out_valid` rises in cycle T+5.
- Bypass latency: `out_valid` rises in cycle T+1, and `out_data` equals the accepted `in_data`.
- Output side:
  - If `out_ready` is high in the first DONE cycle, `in_ready` is high the next cycle.
  - Minimum period is therefore 6 cycles per mixed block and 2 per bypassed block.
- Asynchronous `rst` in any state, including mid-BUSY:
  - Immediately returns to IDLE with `out_valid`=0 and the state register cleared.
  - The partial result is discarded and no output is produced.
- `in_valid` held high across a completed transaction is accepted again only on the next IDLE cycle.

## Structure
- Shared package `aes_pkg`: constants `AES_STATE_W`=128, `AES_COL_W`=32, `AES_NCOL`=4; FSM state enum `mcs_state_t` {IDLE, BUSY, DONE}.
- One sub-module instance: the existing combinational `mul_cols_enc` (32-bit in, 32-bit out).
- The column select and write-back live in this block: a 4:1 mux on the read side and a decoded slot enable on the write side.

## Test plan
- Mix: `in_data`=db135345_f20a225c_01010101_c6c6c6c6, `in_bypass`=0, `out_ready`=1 → `out_valid` in cycle T+5 with `out_data`=8e4da1bc_9fdc589d_01010101_c6c6c6c6, held 1 cycle; `in_ready` returns the next cycle.
- Mix: `in_data`=d4d4d4d5_2d26314c_db135345_01010101 → `out_data`=d5d5d7d6_4d7ebdf8_8e4da1bc_01010101.
- Bypass: `in_data`=00112233_44556677_8899aabb_ccddeeff, `in_bypass`=1 → `out_valid` in cycle T+1, `out_data` identical to `in_data`.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` rises → `out_data` stable, `in_ready`=0, and an `in_valid` pulse is not accepted; release `out_ready` → one transfer, then IDLE.
- Reset mid-BUSY: assert `rst` during cycle T+2 → `out_valid`, `busy` and `out_data` go to 0 asynchronously; after release, a new transaction yields a correct result.
- Back-to-back: 3 transactions with `in_valid` held high and `out_ready`=1 → accepts spaced exactly 6 cycles apart, outputs in order with correct values.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath constants, the MixColumns sequencer state type, and GF(2^8) helpers.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W   = 32;
    localparam int AES_NCOL    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mcs_state_t;

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mul_cols_enc.sv
// Combinational MixColumns on one 32-bit column; byte 0 is bits [31:24].
// Zero latency, no handshake.
module mul_cols_enc
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_in,
    output logic [AES_COL_W-1:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    // 3*a is xtime(a)^a, so each row is {2,3,1,1} rotated.
    assign col_out[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    assign col_out[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    assign col_out[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    assign col_out[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mix_cols_seq.sv
// Sequenced MixColumns: one column per cycle through a shared column unit, result after 5 cycles
// (1 when bypassed); holds the result in DONE until out_ready, accepts nothing until back in IDLE.
module mix_cols_seq
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   in_bypass,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    mcs_state_t             state;
    logic [AES_STATE_W-1:0] st;
    logic [1:0]             col;
    logic [AES_COL_W-1:0]   col_in;
    logic [AES_COL_W-1:0]   col_out;

    always_comb begin
        col_in = st[127:96];
        case (col)
            2'd0:    col_in = st[127:96];
            2'd1:    col_in = st[95:64];
            2'd2:    col_in = st[63:32];
            default: col_in = st[31:0];
        endcase
    end

    mul_cols_enc u_mul_cols_enc (
        .col_in  (col_in),
        .col_out (col_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            col   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st    <= in_data;
                        col   <= '0;
                        state <= in_bypass ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    // In-place write-back into the slot currently selected by col.
                    for (int c = 0; c < AES_NCOL; c++) begin
                        if (col == 2'(c))
                            st[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W] <= col_out;
                    end
                    col <= col + 2'd1;
                    if (col == 2'd3)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = st;

endmodule

// File: tb/tb_mix_cols_seq.sv
// Bench for mix_cols_seq: directed vectors, backpressure, reset mid-BUSY, back-to-back and random traffic
// checked against a generic GF(2^8) matrix-multiply model.
module tb_mix_cols_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    mix_cols_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Generic shift-and-add GF(2^8) multiply, reduced by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   m [4];
        m[0] = 8'd2; m[1] = 8'd3; m[2] = 8'd1; m[3] = 8'd1;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc;
                acc = '0;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k - row + 4) % 4], a[k]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // Present one transaction with out_ready=1 and check latency, data and return to IDLE.
    task automatic run_xact(input logic [127:0] d, input logic byp, input logic [127:0] exp);
        int k;
        int lat;
        out_ready = 1'b1;
        in_data   = d;
        in_bypass = byp;
        in_valid  = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL accept_wait: in_ready=%b after %0d cycles, required 1", in_ready, k);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_bypass = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_accept: busy=%b required 1", busy);
        end
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        tests++;
        if (lat != (byp ? 1 : 5)) begin
            fails++;
            $display("FAIL latency: out_valid in T+%0d, required T+%0d", lat, byp ? 1 : 5);
        end
        tests++;
        if (out_data !== exp) begin
            fails++;
            $display("FAIL out_data: got %h required %h", out_data, exp);
        end
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_transfer: out_valid=%b in_ready=%b busy=%b required 0/1/0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_bypass = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'd0) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b busy=%b out_data=%h required 0/0/0",
                     out_valid, busy, out_data);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_mix_vectors();
        run_xact(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
        run_xact(128'hd4d4d4d5_2d26314c_db135345_01010101, 1'b0,
                 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_01010101);
    endtask

    task automatic test_bypass();
        run_xact(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
                 128'h00112233_44556677_8899aabb_ccddeeff);
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        logic [127:0] exp;
        int lat;
        d = {$urandom, $urandom, $urandom, $urandom};
        exp = ref_mix(d);
        out_ready = 1'b0;
        in_data = d; in_bypass = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_valid: out_valid=%b required 1", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                in_valid = 1'b1;
                in_data  = ~d;
            end else begin
                in_valid = 1'b0;
            end
            tests++;
            if (out_data !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d]: out_data=%h out_valid=%b in_ready=%b required %h/1/0",
                         i, out_data, out_valid, in_ready, exp);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_pulse_ignored: busy=%b out_valid=%b required 0/0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        in_data = d; in_bypass = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'd0) begin
            fails++;
            $display("FAIL reset_mid_busy: out_valid=%b busy=%b out_data=%h required 0/0/0",
                     out_valid, busy, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        run_xact(d, 1'b0, ref_mix(d));
    endtask

    task automatic test_back_to_back();
        logic [127:0] vec [3];
        int acc_cyc [3];
        int nacc;
        int nout;
        logic acc_now;
        for (int i = 0; i < 3; i++) vec[i] = {$urandom, $urandom, $urandom, $urandom};
        nacc = 0; nout = 0;
        out_ready = 1'b1; in_bypass = 1'b0;
        in_data = vec[0]; in_valid = 1'b1;
        for (int k = 0; k < 60 && (nacc < 3 || nout < 3); k++) begin
            acc_now = in_valid && in_ready;
            if (out_valid && out_ready && nout < 3) begin
                tests++;
                if (out_data !== ref_mix(vec[nout])) begin
                    fails++;
                    $display("FAIL b2b_data[%0d]: got %h required %h", nout, out_data, ref_mix(vec[nout]));
                end
                nout++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                if (nacc < 3) in_data = vec[nacc];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tests++;
        if (nacc != 3 || nout != 3) begin
            fails++;
            $display("FAIL b2b_count: accepts=%0d outputs=%0d required 3/3", nacc, nout);
        end else begin
            for (int i = 1; i < 3; i++) begin
                tests++;
                if (acc_cyc[i] - acc_cyc[i-1] != 6) begin
                    fails++;
                    $display("FAIL b2b_spacing[%0d]: %0d cycles required 6", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] d;
        logic [127:0] exp;
        logic byp;
        int lat;
        int stall;
        for (int n = 0; n < 16; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            byp = 1'($urandom_range(0, 1));
            exp = byp ? d : ref_mix(d);
            stall = $urandom_range(0, 3);
            out_ready = 1'b0;
            in_data = d; in_bypass = byp; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0; in_bypass = 1'b0; in_data = ~d;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 20) begin
                @(posedge clk); #1; lat++;
            end
            tests++;
            if (lat != (byp ? 1 : 5) || out_data !== exp) begin
                fails++;
                $display("FAIL rand[%0d]: lat=%0d out_data=%h required lat=%0d data=%h",
                         n, lat, out_data, byp ? 1 : 5, exp);
            end
            repeat (stall) @(posedge clk);
            #1;
            out_ready = 1'b1;
            tests++;
            if (out_data !== exp || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL rand_hold[%0d]: out_data=%h out_valid=%b required %h/1",
                         n, out_data, out_valid, exp);
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_mix_vectors();
        test_bypass();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
